// File: rtl/l2_stream_ptr_if.sv
// Handshake bundle for one L2 stream pointer controller.
// Modport slave is the controller side, master is the environment side.
interface l2_stream_ptr_if #(
    parameter int addr_width   = 64,
    parameter int l2_ncl_width = 8
);
    logic                    i_rst_v;
    logic                    i_rst_r;
    logic [addr_width-1:0]   i_rst_ea_b;
    logic [addr_width-1:0]   i_rst_ea_e;
    logic                    o_rst_v;
    logic                    o_rst_r;
    logic                    o_rst_end;
    logic                    i_rd_v;
    logic                    i_rd_r;
    logic                    o_addr_v;
    logic                    o_addr_r;
    logic [l2_ncl_width-1:0] o_addr_ptr;
    logic                    o_req_v;
    logic                    o_req_r;
    logic                    i_rsp_v;
    logic                    i_rsp_r;

    modport slave (
        input  i_rst_v, i_rst_ea_b, i_rst_ea_e,
        output i_rst_r,
        output o_rst_v, o_rst_end,
        input  o_rst_r,
        input  i_rd_v,
        output i_rd_r,
        output o_addr_v, o_addr_ptr,
        input  o_addr_r,
        output o_req_v,
        input  o_req_r,
        input  i_rsp_v,
        output i_rsp_r
    );

    modport master (
        output i_rst_v, i_rst_ea_b, i_rst_ea_e,
        input  i_rst_r,
        input  o_rst_v, o_rst_end,
        output o_rst_r,
        output i_rd_v,
        input  i_rd_r,
        input  o_addr_v, o_addr_ptr,
        output o_addr_r,
        input  o_req_v,
        output o_req_r,
        output i_rsp_v,
        input  i_rsp_r
    );
endinterface

// File: rtl/l2_stream_ptr_ctrl.sv
// Per-stream pointer/credit controller for the L2 multi-stream buffer.
// Optional simulation checks: define L2_STREAM_PTR_ASSERT_EN.
module l2_stream_ptr_ctrl #(
    parameter int addr_width   = 64,
    parameter int l2_ncl       = 256,
    parameter int l2_ncl_width = $clog2(l2_ncl),
    parameter int cl_width     = 7
) (
    input logic clk,
    input logic reset,
    l2_stream_ptr_if.slave bus
);
    typedef logic [l2_ncl_width:0]   cnt_t;
    typedef logic [l2_ncl_width-1:0] ptr_t;
    typedef logic [addr_width-1:0]   ea_t;

    localparam cnt_t ncl_cnt = cnt_t'(l2_ncl);
    localparam ea_t  lo_mask =
        {{(addr_width-cl_width){1'b0}}, {cl_width{1'b1}}};
    localparam ea_t  line_bytes = lo_mask + ea_t'(1);

    ea_t  req_ea;
    ea_t  end_ea;
    cnt_t outstanding;
    cnt_t filled;
    ptr_t rd_ptr;
    ptr_t wr_ptr;
    logic rst_v_q;
    logic rst_end_q;
    logic addr_v_q;
    ptr_t addr_ptr_q;

    cnt_t occ;
    logic req_v;
    logic rd_r;
    logic rst_r;
    logic req_fire;
    logic rd_fire;
    logic rsp_ok;
    logic rst_fire;

    assign occ   = outstanding + filled;
    assign req_v = (req_ea < end_ea) && (occ < ncl_cnt) && !rst_v_q;
    assign rd_r  = (filled != '0) && (!addr_v_q || bus.o_addr_r)
                   && !rst_v_q;
    assign rst_r = !reset && (outstanding == '0) && !rst_v_q;

    assign req_fire = req_v && bus.o_req_r;
    assign rd_fire  = rd_r && bus.i_rd_v;
    // a response with nothing outstanding is a stale one: swallow it
    assign rsp_ok   = bus.i_rsp_v && !reset && (outstanding != '0);
    assign rst_fire = bus.i_rst_v && rst_r;

    assign bus.i_rst_r    = rst_r;
    assign bus.o_rst_v    = rst_v_q;
    assign bus.o_rst_end  = rst_end_q;
    assign bus.i_rd_r     = rd_r;
    assign bus.o_addr_v   = addr_v_q;
    assign bus.o_addr_ptr = addr_ptr_q;
    assign bus.o_req_v    = req_v;
    assign bus.i_rsp_r    = !reset;

    // credit counters, ring pointers and the registered handshakes
    always_ff @(posedge clk) begin
        if (reset) begin
            req_ea      <= '0;
            end_ea      <= '0;
            outstanding <= '0;
            filled      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            rst_v_q     <= 1'b0;
            rst_end_q   <= 1'b0;
            addr_v_q    <= 1'b0;
            addr_ptr_q  <= '0;
        end else begin
            outstanding <= outstanding + cnt_t'(req_fire)
                           - cnt_t'(rsp_ok);
            filled      <= filled + cnt_t'(rsp_ok) - cnt_t'(rd_fire);
            if (rsp_ok)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_fire)
                rd_ptr <= rd_ptr + ptr_t'(1);
            if (req_fire)
                req_ea <= req_ea + line_bytes;
            if (rd_fire) begin
                addr_v_q   <= 1'b1;
                addr_ptr_q <= rd_ptr;
            end else if (bus.o_addr_r) begin
                addr_v_q <= 1'b0;
            end
            if (rst_v_q && bus.o_rst_r)
                rst_v_q <= 1'b0;
            if (rst_fire) begin
                req_ea    <= bus.i_rst_ea_b & ~lo_mask;
                end_ea    <= bus.i_rst_ea_e;
                filled    <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                rst_v_q   <= 1'b1;
                rst_end_q <= (bus.i_rst_ea_b >= bus.i_rst_ea_e);
            end
        end
    end

`ifdef L2_STREAM_PTR_ASSERT_EN
    logic post_rst;
    logic prev_addr_v;
    logic prev_addr_r;
    ptr_t prev_ptr;

    // protocol sanity checks for simulation builds
    always_ff @(posedge clk) begin
        if (reset) begin
            post_rst    <= 1'b1;
            prev_addr_v <= 1'b0;
            prev_addr_r <= 1'b0;
            prev_ptr    <= '0;
        end else begin
            if (req_fire)
                post_rst <= 1'b0;
            if (bus.i_rsp_v && outstanding == '0 && !post_rst)
                $error("response with nothing outstanding");
            if (occ > ncl_cnt)
                $error("occupancy above buffer size");
            if (prev_addr_v && !prev_addr_r &&
                (!addr_v_q || addr_ptr_q != prev_ptr))
                $error("addr output changed while stalled");
            prev_addr_v <= addr_v_q;
            prev_addr_r <= bus.o_addr_r;
            prev_ptr    <= addr_ptr_q;
        end
    end
`endif

endmodule

// File: tb/tb_l2_stream_ptr_ctrl.sv
// Directed bench for l2_stream_ptr_ctrl with a queue-based
// stream model compared every cycle plus literal expectations.
module tb_l2_stream_ptr_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l2_stream_ptr_if #(.addr_width(64), .l2_ncl_width(8)) bus ();

    l2_stream_ptr_ctrl #(
        .addr_width(64), .l2_ncl(256), .l2_ncl_width(8), .cl_width(7)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int errs = 0;
    int checks = 0;
    bit chk_en = 0;

    // response generator: one response per earlier request
    bit rsp_en = 0;
    int pend = 0;
    assign bus.i_rsp_v = rsp_en && (pend != 0);
    always @(posedge clk) begin
        if (reset) pend <= 0;
        else pend <= pend + int'(bus.o_req_v && bus.o_req_r)
                          - int'(bus.i_rsp_v && bus.i_rsp_r);
    end

    // stream model
    int          m_out;
    int          m_wr;
    int          fillq[$];
    longint unsigned m_req, m_end;
    bit          m_rst_v, m_rst_end, m_addr_v;
    int          m_addr_ptr;

    function automatic bit e_req();
        return (m_req < m_end) && (m_out + fillq.size() < 256) && !m_rst_v;
    endfunction
    function automatic bit e_rd_r();
        return fillq.size() != 0 && (!m_addr_v || bus.o_addr_r) && !m_rst_v;
    endfunction
    function automatic bit e_rst_r();
        return !reset && m_out == 0 && !m_rst_v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_out = 0; m_wr = 0; fillq.delete();
            m_req = 0; m_end = 0;
            m_rst_v = 0; m_rst_end = 0; m_addr_v = 0; m_addr_ptr = 0;
        end else begin
            bit rq, rd, rs, rf, ack;
            rq  = e_req() && bus.o_req_r;
            rd  = e_rd_r() && bus.i_rd_v;
            rs  = bus.i_rsp_v && m_out > 0;
            rf  = bus.i_rst_v && e_rst_r();
            ack = m_rst_v && bus.o_rst_r;
            m_out = m_out + int'(rq) - int'(rs);
            if (rd) begin
                m_addr_v = 1;
                m_addr_ptr = fillq.pop_front();
            end else if (bus.o_addr_r) begin
                m_addr_v = 0;
            end
            if (rs) begin
                fillq.push_back(m_wr % 256);
                m_wr++;
            end
            if (rq) m_req += 128;
            if (ack) m_rst_v = 0;
            if (rf) begin
                m_req = bus.i_rst_ea_b & ~64'd127;
                m_end = bus.i_rst_ea_e;
                fillq.delete();
                m_wr = 0;
                m_rst_v = 1;
                m_rst_end = bus.i_rst_ea_b >= bus.i_rst_ea_e;
            end
        end
    end

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // per-cycle compare of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_req_v", bus.o_req_v, e_req());
            chk("i_rd_r", bus.i_rd_r, e_rd_r());
            chk("i_rst_r", bus.i_rst_r, e_rst_r());
            chk("i_rsp_r", bus.i_rsp_r, !reset);
            chk("o_rst_v", bus.o_rst_v, m_rst_v);
            chk("o_rst_end", bus.o_rst_end, m_rst_end);
            chk("o_addr_v", bus.o_addr_v, m_addr_v);
            chk("o_addr_ptr", bus.o_addr_ptr, m_addr_ptr);
        end
    end

    // event monitors feeding the literal expectations
    int n_req = 0;
    int n_rst = 0;
    int n_rd_r = 0;
    bit last_end = 0;
    int addr_log[$];
    always @(negedge clk) begin
        if (bus.o_rst_v) begin n_rst++; last_end = bus.o_rst_end; end
        if (bus.i_rd_r) n_rd_r++;
        if (bus.o_addr_v && bus.o_addr_r) addr_log.push_back(int'(bus.o_addr_ptr));
    end
    always @(posedge clk)
        if (!reset && bus.o_req_v && bus.o_req_r) n_req++;

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rst(longint b, longint e);
        bus.i_rst_v = 1; bus.i_rst_ea_b = b; bus.i_rst_ea_e = e;
        cyc(1);
        bus.i_rst_v = 0;
    endtask

    initial begin
        bus.i_rst_v = 0; bus.i_rst_ea_b = 0; bus.i_rst_ea_e = 0;
        bus.o_rst_r = 1; bus.i_rd_v = 0; bus.o_addr_r = 1; bus.o_req_r = 1;
        cyc(1);
        chk_en = 1;
        cyc(2);
        chk("reset i_rst_r", bus.i_rst_r, 0);
        chk("reset o_req_v", bus.o_req_v, 0);
        reset = 0;
        rsp_en = 1;
        cyc(1);
        n_req = 0; n_rst = 0;

        // test 1 with test 3 (dropped reset while outstanding)
        do_rst(32768, 65536);
        cyc(10);
        bus.i_rst_v = 1; bus.i_rst_ea_b = 384; bus.i_rst_ea_e = 38400;
        chk("t3 i_rst_r busy", bus.i_rst_r, 0);
        cyc(1);
        bus.i_rst_v = 0;
        cyc(2);
        chk("t3 no rst pulse", bus.o_rst_v, 0);
        cyc(300);
        chk("t1 req beats", n_req, 256);
        chk("t1 rst pulses", n_rst, 1);
        chk("t1 rst_end", last_end, 0);
        chk("t1 filled", fillq.size(), 256);
        chk("t1 drained", pend, 0);

        // test 2: two reads after end of stream
        addr_log.delete();
        bus.i_rd_v = 1; cyc(1); bus.i_rd_v = 0; cyc(2);
        bus.i_rd_v = 1; cyc(1); bus.i_rd_v = 0; cyc(5);
        chk("t2 reads", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk("t2 ptr0", addr_log[0], 0);
            chk("t2 ptr1", addr_log[1], 1);
        end
        chk("t2 no new req", n_req, 256);

        // test 4: fresh stream stalls on full buffer
        n_req = 0; n_rst = 0;
        do_rst(512, 65536);
        cyc(300);
        chk("t4 req beats", n_req, 256);
        addr_log.delete();
        bus.i_rd_v = 1; cyc(1); bus.i_rd_v = 0;
        cyc(20);
        chk("t4 one more req", n_req, 257);
        chk("t4 reads", addr_log.size(), 1);
        if (addr_log.size() == 1) chk("t4 ptr", addr_log[0], 0);

        // test 5: empty stream
        n_req = 0; n_rst = 0;
        do_rst(4096, 4096);
        n_rd_r = 0;
        cyc(20);
        chk("t5 rst pulses", n_rst, 1);
        chk("t5 rst_end", last_end, 1);
        chk("t5 no req", n_req, 0);
        chk("t5 rd_r low", n_rd_r, 0);

        // test 6: stalled address output, unaligned begin
        n_req = 0;
        do_rst(100, 1024);
        cyc(20);
        chk("t6 req beats", n_req, 8);
        bus.o_addr_r = 0;
        bus.i_rd_v = 1;
        cyc(1);
        chk("t6 addr_v", bus.o_addr_v, 1);
        chk("t6 ptr hold a", bus.o_addr_ptr, 0);
        chk("t6 rd_r stall", bus.i_rd_r, 0);
        cyc(3);
        chk("t6 ptr hold b", bus.o_addr_ptr, 0);
        chk("t6 rd_r still", bus.i_rd_r, 0);
        bus.o_addr_r = 1;
        cyc(1);
        bus.i_rd_v = 0;
        chk("t6 ptr next", bus.o_addr_ptr, 1);
        cyc(1);
        chk("t6 addr drop", bus.o_addr_v, 0);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
